fetch_unit: RTL and testbench

Instruction fetch stage feeding the stall queue. It holds the program counter and issues word reads to a fixed-latency pipelined instruction memory. Returned instructions are buffered in a small credit-controlled FIFO and presented downstream as `cur_instruction`/`cur_pc`. The stage honours downstream `stall` by holding its output and redirects on `flush` by discarding everything buffered or in flight.

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to a fixed-latency pipelined
// instruction memory and buffers returned words in a credit-controlled FIFO.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter int          MEM_LAT  = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [15:0] flush_pc,
  input  logic        stall,
  output logic        mem_ren,
  output logic [15:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] cur_instruction,
  output logic [15:0] cur_pc,
  output logic        cur_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  // One extra bit so count + inflight never overflows before the compare.
  localparam int SUM_W = CNT_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [15:0]        pc_q, pc_d;
  logic [MEM_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [15:0]        pipe_pc_q [MEM_LAT];
  logic [15:0]        pipe_pc_d [MEM_LAT];
  logic [15:0]        fifo_pc_q [DEPTH];
  logic [15:0]        fifo_pc_d [DEPTH];
  logic [15:0]        fifo_instr_q [DEPTH];
  logic [15:0]        fifo_instr_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [SUM_W-1:0]   inflight;
  logic               issue, enq, deq;

  // Downstream handshake: an entry transfers when cur_valid=1 and stall=0 with no
  // flush; while stalled the head entry and cur_* stay stable.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + SUM_W'(pipe_v_q[i]);
    end
    cur_valid = (count_q != '0);
    issue     = rst_n & ~flush & ((SUM_W'(count_q) + inflight) < SUM_W'(DEPTH));
    enq       = pipe_v_q[MEM_LAT-1] & ~flush;
    deq       = cur_valid & ~stall & ~flush;
  end

  assign mem_ren         = issue;
  assign mem_raddr       = pc_q;
  assign cur_pc          = cur_valid ? fifo_pc_q[head_q] : 16'h0000;
  assign cur_instruction = cur_valid ? fifo_instr_q[head_q] : 16'h0000;

  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = flush_pc;
    end else if (issue) begin
      pc_d = pc_q + 16'd1;
    end

    pipe_v_d     = '0;
    pipe_v_d[0]  = issue;
    pipe_pc_d[0] = pc_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v_d[i]  = pipe_v_q[i-1] & ~flush;
      pipe_pc_d[i] = pipe_pc_q[i-1];
    end

    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    if (enq) begin
      fifo_pc_d[tail_q]    = pipe_pc_q[MEM_LAT-1];
      fifo_instr_d[tail_q] = mem_rdata;
    end

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq) head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
      if (enq) tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      pipe_v_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_pc_q[i] <= 16'h0000;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      pipe_v_q  <= pipe_v_d;
      pipe_pc_q <= pipe_pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Payload storage needs no reset: count_q gates visibility of every entry.
  always_ff @(posedge clk) begin
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/flush traffic, checked
// cycle by cycle against a queue-based transaction model of the fetch stage.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam int          MEM_LAT  = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] KEY      = 16'hA5A5;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] flush_pc;
  logic        stall;
  logic        mem_ren;
  logic [15:0] mem_raddr;
  logic [15:0] mem_rdata;
  logic [15:0] cur_instruction;
  logic [15:0] cur_pc;
  logic        cur_valid;

  int vectors;
  int miscompares;

  fetch_unit #(
    .DEPTH(DEPTH),
    .MEM_LAT(MEM_LAT),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .flush_pc(flush_pc),
    .stall(stall),
    .mem_ren(mem_ren),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .cur_instruction(cur_instruction),
    .cur_pc(cur_pc),
    .cur_valid(cur_valid)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word at address a is a ^ KEY, returned MEM_LAT cycles after the request.
  logic [15:0] addr_d [MEM_LAT];
  always @(posedge clk) begin
    addr_d[0] <= mem_raddr;
    for (int i = 1; i < MEM_LAT; i++) addr_d[i] <= addr_d[i-1];
  end
  assign mem_rdata = addr_d[MEM_LAT-1] ^ KEY;

  // Reference model: buffered PCs (exp_q) and outstanding requests with due cycle.
  logic [15:0] exp_q[$];
  logic [15:0] fl_pc_q[$];
  int          fl_due_q[$];
  logic [15:0] m_pc;
  int          cyc;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fl_pc_q.delete();
    fl_due_q.delete();
    m_pc = RESET_PC;
    cyc  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 16'(cur_valid), 16'h0000);
    chk({tag, "_pc"}, cur_pc, 16'h0000);
    chk({tag, "_instr"}, cur_instruction, 16'h0000);
    chk({tag, "_ren"}, 16'(mem_ren), 16'h0000);
  endtask

  // Driver: called at a falling edge; applies inputs, checks, advances one cycle.
  task automatic step(input logic f, input logic [15:0] fpc, input logic s);
    logic        m_ren;
    logic [15:0] hd;
    flush    = f;
    flush_pc = fpc;
    stall    = s;
    #1;
    m_ren = !f && ((exp_q.size() + fl_pc_q.size()) < DEPTH);
    hd    = (exp_q.size() != 0) ? exp_q[0] : 16'h0000;
    chk("mem_ren", 16'(mem_ren), 16'(m_ren));
    chk("mem_raddr", mem_raddr, m_pc);
    chk("cur_valid", 16'(cur_valid), 16'(exp_q.size() != 0));
    chk("cur_pc", cur_pc, hd);
    chk("cur_instr", cur_instruction, (exp_q.size() != 0) ? (hd ^ KEY) : 16'h0000);
    if (f) begin
      exp_q.delete();
      fl_pc_q.delete();
      fl_due_q.delete();
      m_pc = fpc;
    end else begin
      if (exp_q.size() != 0 && !s) void'(exp_q.pop_front());
      if (fl_due_q.size() != 0 && fl_due_q[0] == cyc) begin
        exp_q.push_back(fl_pc_q.pop_front());
        void'(fl_due_q.pop_front());
      end
      if (m_ren) begin
        fl_pc_q.push_back(m_pc);
        fl_due_q.push_back(cyc + MEM_LAT);
        m_pc = m_pc + 16'd1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic first_fetch_checks(input string tag);
    flush = 1'b0;
    stall = 1'b0;
    #1;
    chk({tag, "_valid"}, 16'(cur_valid), 16'h0001);
    chk({tag, "_pc"}, cur_pc, RESET_PC);
    chk({tag, "_instr"}, cur_instruction, RESET_PC ^ KEY);
  endtask

  task automatic redirect_checks(input string tag, input logic [15:0] target);
    flush = 1'b0;
    #1;
    chk({tag, "_valid_drop"}, 16'(cur_valid), 16'h0000);
    chk({tag, "_raddr"}, mem_raddr, target);
    repeat (3) step(1'b0, 16'h0000, 1'b0);
    #1;
    chk({tag, "_first_valid"}, 16'(cur_valid), 16'h0001);
    chk({tag, "_first_pc"}, cur_pc, target);
  endtask

  initial begin
    logic [15:0] wrap_pc;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    flush_pc    = 16'h0000;
    stall       = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Reset release: first instruction in cycle 3, then one per cycle.
    repeat (3) step(1'b0, 16'h0000, 1'b0);
    first_fetch_checks("first");
    repeat (2) step(1'b0, 16'h0000, 1'b0);

    // Ten-cycle stall from cycle 5: credits saturate and issue stops.
    repeat (10) step(1'b0, 16'h0000, 1'b1);
    #1;
    chk("stall_ren_off", 16'(mem_ren), 16'h0000);
    repeat (6) step(1'b0, 16'h0000, 1'b0);

    // Flush with entries buffered and requests in flight.
    repeat (2) step(1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'h0100, 1'b0);
    redirect_checks("flush", 16'h0100);
    repeat (4) step(1'b0, 16'h0000, 1'b0);

    // Flush and stall together while a response is arriving.
    step(1'b1, 16'h0200, 1'b1);
    redirect_checks("flush_stall", 16'h0200);
    repeat (3) step(1'b0, 16'h0000, 1'b0);

    // PC wrap after redirect near the top of the address space.
    step(1'b1, 16'hFFFE, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wrap_pc = 16'hFFFE + 16'(i);
      flush   = 1'b0;
      stall   = 1'b0;
      #1;
      chk("wrap_pc", cur_pc, wrap_pc);
      step(1'b0, 16'h0000, 1'b0);
    end

    // Random stall/flush traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 4), 16'($urandom), 1'($urandom_range(0, 99) < 35));
    end
    repeat (3) step(1'b0, 16'h0000, 1'b0);

    // Asynchronous reset pulse between edges, then a clean restart.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 16'h0000, 1'b0);
    first_fetch_checks("restart");
    repeat (6) step(1'b0, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
